// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with E0/F0 prefix folding and a first-word-fall-through
// scan-code FIFO. The optional macro PS2_INHIBIT_EN makes the receiver hold
// ps2_clk low while the FIFO is full and the receiver is idle.
//
// state | meaning
// IDLE  | waiting for a start bit on a ps2_clk falling edge
// RECV  | shifting in 8 data bits, then parity, then stop
// CHECK | one cycle to validate the frame and push/fold the byte
module ps2_rx_fifo #(
  parameter int DEPTH      = 8,
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic                     CLOCK_50,
  input  logic                     Resetn,
  inout  wire                      ps2_clk,
  inout  wire                      ps2_dat,
  input  logic                     rd_en,
  input  logic                     clear,
  output logic [7:0]               code,
  output logic                     brk,
  output logic                     ext,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int TW     = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t          state_q, state_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d, stop_q, stop_d;
  logic            err_d, byte_ok, flag_clr;
  logic            clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic            fall, fall_mask, timeout;
  logic [TW-1:0]   to_q;
  logic            ext_f, brk_f;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [9:0]      mem [DEPTH];
  logic [9:0]      head;
  logic            push_req, push_ok, pop;

`ifdef PS2_INHIBIT_EN
  logic       inhibit_q;
  logic [2:0] inh_hist;

  // Hold the device off while the FIFO is full; only ever start from IDLE.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      inhibit_q <= 1'b0;
      inh_hist  <= '0;
    end else begin
      inhibit_q <= full && (state_q == IDLE);
      inh_hist  <= {inh_hist[1:0], inhibit_q};
    end
  end

  // Our own pull-down shows up as a falling edge after synchronisation; ignore it.
  assign fall_mask = inhibit_q | (|inh_hist);
  assign ps2_clk   = inhibit_q ? 1'b0 : 1'bz;
`else
  assign fall_mask = 1'b0;
  assign ps2_clk   = 1'bz;
`endif

  assign ps2_dat = 1'bz;

  // Two-flop synchronisers; idle lines are high, so reset to 1 to avoid a false edge.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2 & ~fall_mask;

  // Inter-edge watchdog: reloaded on every falling edge, counts down to zero.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn)            to_q <= TW'(TO_CYC - 1);
    else if (fall)          to_q <= TW'(TO_CYC - 1);
    else if (to_q != '0)    to_q <= to_q - TW'(1);
  end

  assign timeout = (to_q == '0);

  // Receive FSM state and frame shift registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      frame_err <= err_d;
    end
  end

  // Next-state logic: sample on falling edges, validate in CHECK.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    stop_d   = stop_q;
    err_d    = 1'b0;
    byte_ok  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          if (!dat_s2) begin
            state_d  = RECV;
            bitcnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (fall) begin
          if (bitcnt_q < 4'd8) begin
            sh_d = {dat_s2, sh_q[7:1]};
          end else if (bitcnt_q == 4'd8) begin
            par_d = dat_s2;
          end else begin
            stop_d  = dat_s2;
            state_d = CHECK;
          end
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if ((^{sh_q, par_q}) && stop_q) byte_ok = 1'b1;
        else                            err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A start-bit glitch in IDLE is reported but keeps any pending prefix.
  assign flag_clr = err_d && (state_q != IDLE);
  assign push_req = byte_ok && (sh_q != 8'hE0) && (sh_q != 8'hF0);
  assign pop      = rd_en && !empty;
  assign push_ok  = push_req && (!full || pop);

  // Prefix flags fold E0/F0 into the next real scan code.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (clear || flag_clr) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (byte_ok) begin
      if (sh_q == 8'hE0) begin
        ext_f <= 1'b1;
      end else if (sh_q == 8'hF0) begin
        brk_f <= 1'b1;
      end else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow; clear wins over push/pop.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)             wr_ptr   <= wr_ptr + AW'(1);
      if (pop)                 rd_ptr   <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // Storage array; contents are only visible through the head when non-empty.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok && !clear) mem[wr_ptr] <= {ext_f, brk_f, sh_q};
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign code  = empty ? 8'h00 : head[7:0];
  assign brk   = empty ? 1'b0  : head[8];
  assign ext   = empty ? 1'b0  : head[9];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: device frames are bit-banged onto ps2_clk/ps2_dat
// with a 20-cycle bit period; clock and timeout are scaled down (TO_CYC = 400).
module tb_ps2_rx_fifo;
  localparam int DEPTH      = 4;
  localparam int CLK_HZ     = 2000000;
  localparam int TIMEOUT_US = 200;
  localparam int TO_CYC     = 400;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn, rd_en, clear, dev_clk, dev_dat;
  wire        ps2_clk, ps2_dat;
  logic [7:0] code;
  logic       brk, ext, empty, full, frame_err, overflow;
  logic [2:0] count;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   err_cnt  = 0;
  logic snap3_empty, snap4_empty, snap4_err, snap5_err;

  always #5 CLOCK_50 = ~CLOCK_50;

  // Device side drives both lines; the receiver only ever releases them here.
  assign ps2_clk = dev_clk;
  assign ps2_dat = dev_dat;

  ps2_rx_fifo #(.DEPTH(DEPTH), .CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rd_en    (rd_en),
    .clear    (clear),
    .code     (code),
    .brk      (brk),
    .ext      (ext),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  // Count frame_err high cycles, sampled mid-cycle.
  always @(negedge CLOCK_50) if (Resetn === 1'b1 && frame_err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_bit(input logic b);
    dev_dat = b;
    tick(5);
    dev_clk = 1'b0;
    tick(10);
    dev_clk = 1'b1;
    tick(5);
  endtask

  // Full frame; the stop bit is unrolled to snapshot the CHECK timing.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic pop_at_check);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ par_flip);
    dev_dat = 1'b1;
    tick(5);
    dev_clk = 1'b0;
    tick(3);
    snap3_empty = empty;
    if (pop_at_check) rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    snap4_empty = empty;
    snap4_err   = frame_err;
    tick(1);
    snap5_err = frame_err;
    tick(5);
    dev_clk = 1'b1;
    tick(5);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    int         e0;
    int         n;
    logic [7:0] exp6 [4];
    logic [7:0] exp7 [4];
    logic [7:0] part;
    exp6 = '{8'h15, 8'h16, 8'h1E, 8'h26};
    exp7 = '{8'h12, 8'h13, 8'h14, 8'h21};
    part = 8'h29;

    Resetn = 1'b0; dev_clk = 1'b1; dev_dat = 1'b1; rd_en = 1'b0; clear = 1'b0;
    tick(3);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_code", code, 0);
    check("rst_brk", brk, 0);
    check("rst_ext", ext, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    Resetn = 1'b1;
    tick(5);

    // Plain make code.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t1_empty_in_check", snap3_empty, 1);
    check("t1_empty_after_check", snap4_empty, 0);
    check("t1_code", code, 8'h1C);
    check("t1_brk", brk, 0);
    check("t1_ext", ext, 0);
    check("t1_count", count, 1);
    check("t1_no_err", err_cnt - e0, 0);
    pop_one();
    check("t1_empty_after_pop", empty, 1);

    // Break prefix.
    send_frame(8'hF0, 1'b0, 1'b0);
    check("t2_prefix_not_pushed", count, 0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t2_count", count, 1);
    check("t2_code", code, 8'h1C);
    check("t2_brk", brk, 1);
    check("t2_ext", ext, 0);
    pop_one();

    // Extended break.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("t3_count", count, 1);
    check("t3_code", code, 8'h75);
    check("t3_ext", ext, 1);
    check("t3_brk", brk, 1);
    pop_one();

    // Parity error drops the byte and the pending F0.
    send_frame(8'hF0, 1'b0, 1'b0);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("t4_err_pulse", snap4_err, 1);
    check("t4_err_ends", snap5_err, 0);
    check("t4_err_cycles", err_cnt - e0, 1);
    check("t4_count", count, 0);
    send_frame(8'h32, 1'b0, 1'b0);
    check("t4_next_count", count, 1);
    check("t4_next_code", code, 8'h32);
    check("t4_next_brk", brk, 0);
    pop_one();

    // Timeout after 5 data bits; the pending E0 must be dropped.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(part[i]);
    n = 0;
    while (frame_err !== 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    check("t5_timeout_seen", frame_err, 1);
    check("t5_timeout_window", (n >= TO_CYC - 20 && n <= TO_CYC + 5), 1);
    tick(2);
    send_frame(8'h29, 1'b0, 1'b0);
    check("t5_next_count", count, 1);
    check("t5_next_code", code, 8'h29);
    check("t5_next_ext", ext, 0);
    pop_one();

    // Overflow: fifth code dropped, first four in order.
    send_frame(8'h15, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b0);
    send_frame(8'h26, 1'b0, 1'b0);
    send_frame(8'h25, 1'b0, 1'b0);
    check("t6_full", full, 1);
    check("t6_count", count, 4);
    check("t6_overflow", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("t6_order", code, exp6[i]);
      pop_one();
    end
    check("t6_empty", empty, 1);
    check("t6_overflow_sticky", overflow, 1);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("t6_overflow_cleared", overflow, 0);

    // Push and pop in the same cycle while full.
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h13, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0);
    check("t7_full", full, 1);
    send_frame(8'h21, 1'b0, 1'b1);
    check("t7_count", count, 4);
    check("t7_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check("t7_order", code, exp7[i]);
      pop_one();
    end
    check("t7_empty", empty, 1);

    // clear together with rd_en on a full, overflowed FIFO.
    send_frame(8'h41, 1'b0, 1'b0);
    send_frame(8'h42, 1'b0, 1'b0);
    send_frame(8'h43, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0);
    send_frame(8'h45, 1'b0, 1'b0);
    check("t8_overflow_set", overflow, 1);
    clear = 1'b1; rd_en = 1'b1;
    tick(1);
    clear = 1'b0; rd_en = 1'b0;
    check("t8_count", count, 0);
    check("t8_empty", empty, 1);
    check("t8_full", full, 0);
    check("t8_overflow", overflow, 0);
    check("t8_code", code, 0);

    // Reset in the middle of a frame.
    send_frame(8'h1C, 1'b0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    Resetn = 1'b0;
    tick(1);
    check("t9_rst_empty", empty, 1);
    check("t9_rst_count", count, 0);
    Resetn = 1'b1;
    tick(5);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("t9_count", count, 1);
    check("t9_code", code, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
